// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one flash read port between the CPU and the PCM fetcher, PCM first.
// Define FLASH_ARBITER_STARVATION_GUARD_EN to bound how many PCM grants a waiting CPU sees.
module flash_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 24,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PCM_STREAK_MAX = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cpu_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_cpu_address,
    output logic                     o_cpu_ready,
    output logic [DATA_WIDTH-1:0]    o_cpu_data,
    input  logic                     i_pcm_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_pcm_address,
    output logic                     o_pcm_ready,
    output logic [DATA_WIDTH-1:0]    o_pcm_data,
    output logic                     o_reader_valid,
    output logic [ADDRESS_WIDTH-1:0] o_reader_address,
    input  logic                     i_reader_ready,
    input  logic [DATA_WIDTH-1:0]    i_reader_data,
    output logic                     o_grant_pcm
);

    typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

    state_e                   r_state, w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_reader_address, w_reader_address_next;
    logic [DATA_WIDTH-1:0]    r_cpu_data, w_cpu_data_next;
    logic [DATA_WIDTH-1:0]    r_pcm_data, w_pcm_data_next;
    logic                     r_grant_pcm, w_grant_pcm_next;
    logic                     w_force_cpu;
    logic                     w_take_pcm;

    assign w_take_pcm = i_pcm_valid && !w_force_cpu;

`ifdef FLASH_ARBITER_STARVATION_GUARD_EN
    localparam int unsigned STREAK_W = $clog2(PCM_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(PCM_STREAK_MAX);

    logic [STREAK_W-1:0] r_streak;

    // Counts PCM grants that overtook a waiting CPU; any CPU grant or idle CPU clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_streak <= '0;
        end else if (r_state == StIdle) begin
            if (!i_cpu_valid || !w_take_pcm) begin
                r_streak <= '0;
            end else begin
                r_streak <= r_streak + STREAK_W'(1);
            end
        end
    end

    assign w_force_cpu = i_cpu_valid && (r_streak == STREAK_LIMIT);
`else
    assign w_force_cpu = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= StIdle;
            r_reader_address <= '0;
            r_cpu_data       <= '0;
            r_pcm_data       <= '0;
            r_grant_pcm      <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_reader_address <= w_reader_address_next;
            r_cpu_data       <= w_cpu_data_next;
            r_pcm_data       <= w_pcm_data_next;
            r_grant_pcm      <= w_grant_pcm_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        w_reader_address_next = r_reader_address;
        w_cpu_data_next       = r_cpu_data;
        w_pcm_data_next       = r_pcm_data;
        w_grant_pcm_next      = r_grant_pcm;
        o_reader_valid        = 1'b0;
        o_cpu_ready           = 1'b0;
        o_pcm_ready           = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_take_pcm) begin
                    w_reader_address_next = i_pcm_address;
                    w_grant_pcm_next      = 1'b1;
                    w_state_next          = StBusy;
                end else if (i_cpu_valid) begin
                    w_reader_address_next = i_cpu_address;
                    w_grant_pcm_next      = 1'b0;
                    w_state_next          = StBusy;
                end
            end
            StBusy: begin
                o_reader_valid = 1'b1;
                if (i_reader_ready) begin
                    if (r_grant_pcm) begin
                        w_pcm_data_next = i_reader_data;
                    end else begin
                        w_cpu_data_next = i_reader_data;
                    end
                    w_state_next = StRespond;
                end
            end
            StRespond: begin
                // The following IDLE cycle gives the requester time to drop valid.
                o_cpu_ready  = !r_grant_pcm;
                o_pcm_ready  = r_grant_pcm;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_reader_address = r_reader_address;
    assign o_cpu_data       = r_cpu_data;
    assign o_pcm_data       = r_pcm_data;
    assign o_grant_pcm      = r_grant_pcm;

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter with a fixed-latency flash reader model.
// Starvation expectations follow FLASH_ARBITER_STARVATION_GUARD_EN.
`timescale 1ns/1ps
module tb_flash_arbiter;
    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int RD_LAT = 5;
    localparam int BUDGET = 400;

    typedef struct packed {
        logic          is_pcm;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_valid = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_data;
    logic          pcm_valid = 1'b0;
    logic [AW-1:0] pcm_address = '0;
    logic          pcm_ready;
    logic [DW-1:0] pcm_data;
    logic          reader_valid;
    logic [AW-1:0] reader_address;
    logic          reader_ready = 1'b0;
    logic [DW-1:0] reader_data = '0;
    logic          grant_pcm;

    exp_t          sb_q[$];
    logic [AW-1:0] addr_log[$];
    exp_t          e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            rv_rises = 0;
    int            lat_cnt = 0;
    bit            rd_en = 1'b1;
    bit            inject = 1'b0;
    logic          rv_prev = 1'b0;
    logic          rr_prev = 1'b0;
    logic [DW-1:0] last_cpu = '0;
    logic [DW-1:0] last_pcm = '0;

    flash_arbiter dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_cpu_valid      (cpu_valid),
        .i_cpu_address    (cpu_address),
        .o_cpu_ready      (cpu_ready),
        .o_cpu_data       (cpu_data),
        .i_pcm_valid      (pcm_valid),
        .i_pcm_address    (pcm_address),
        .o_pcm_ready      (pcm_ready),
        .o_pcm_data       (pcm_data),
        .o_reader_valid   (reader_valid),
        .o_reader_address (reader_address),
        .i_reader_ready   (reader_ready),
        .i_reader_data    (reader_data),
        .o_grant_pcm      (grant_pcm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] flash_word(input logic [AW-1:0] a);
        return (a == 24'h100000) ? 32'hDEADBEEF : {8'hA5, a};
    endfunction

    // Flash reader: ready pulses RD_LAT cycles after reader_valid first goes high.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reader_ready) begin
                reader_ready = 1'b0;
            end else if (inject) begin
                reader_ready = 1'b1;
                reader_data  = 32'h12345678;
                inject       = 1'b0;
            end else if (reader_valid && rd_en) begin
                lat_cnt++;
                if (lat_cnt > RD_LAT) begin
                    reader_ready = 1'b1;
                    reader_data  = flash_word(reader_address);
                    lat_cnt      = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (reader_valid && !rv_prev) begin
                rv_rises++;
                addr_log.push_back(reader_address);
            end
            if (rr_prev) check("reader_valid drop after reader_ready", reader_valid, 1'b0);
            if (cpu_ready || pcm_ready) begin
                check("single ready", cpu_ready & pcm_ready, 1'b0);
                check("ready follows reader_ready", rr_prev, 1'b1);
                check("pending expectation", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("grantee", pcm_ready, e.is_pcm);
                    check("grant_pcm", grant_pcm, e.is_pcm);
                    if (e.is_pcm) begin
                        check("pcm_data", pcm_data, e.data);
                        check("cpu_data held", cpu_data, last_cpu);
                        last_pcm = e.data;
                    end else begin
                        check("cpu_data", cpu_data, e.data);
                        check("pcm_data held", pcm_data, last_pcm);
                        last_cpu = e.data;
                    end
                end
            end
        end
        rv_prev = reader_valid;
        rr_prev = reader_ready;
    end

    task automatic wait_ready(input bit pcm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (pcm ? pcm_ready : cpu_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (pcm) check("pcm ready within budget", ok, 1'b1);
        else     check("cpu ready within budget", ok, 1'b1);
    endtask

    task automatic cpu_req(input logic [AW-1:0] addr);
        bit ok;
        cpu_valid   = 1'b1;
        cpu_address = addr;
        wait_ready(1'b0, ok);
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
    endtask

    // Keeps pcm_valid high across n back-to-back requests.
    task automatic pcm_stream(input logic [AW-1:0] base, input int n);
        bit ok;
        pcm_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            pcm_address = base + AW'(4 * i);
            wait_ready(1'b1, ok);
            @(posedge clk);
            #1;
        end
        pcm_valid = 1'b0;
    endtask

    task automatic push(input bit is_pcm, input logic [AW-1:0] addr);
        exp_t x;
        x.is_pcm = is_pcm;
        x.data   = flash_word(addr);
        sb_q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int rv0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset reader_valid", reader_valid, 1'b0);
        check("reset cpu_ready", cpu_ready, 1'b0);
        check("reset pcm_ready", pcm_ready, 1'b0);
        check("reset reader_address", reader_address, 24'h0);
        check("reset cpu_data", cpu_data, 32'h0);
        check("reset pcm_data", pcm_data, 32'h0);
        check("reset grant_pcm", grant_pcm, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single CPU read, with one-cycle grant latency and no re-grant after RESPOND.
        #1;
        rv0 = rv_rises;
        push(1'b0, 24'h100000);
        cpu_valid   = 1'b1;
        cpu_address = 24'h100000;
        @(negedge clk);
        check("reader_valid before grant", reader_valid, 1'b0);
        @(negedge clk);
        check("reader_valid one cycle after cpu_valid", reader_valid, 1'b1);
        check("reader_address cpu", reader_address, 24'h100000);
        wait_ready(1'b0, ok);
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        repeat (8) @(posedge clk);
        check("reader_valid rises for one read", rv_rises - rv0, 1);

        // Simultaneous requests: PCM served first, then CPU.
        #1;
        addr_log.delete();
        push(1'b1, 24'h200000);
        push(1'b0, 24'h000010);
        fork
            cpu_req(24'h000010);
            pcm_stream(24'h200000, 1);
        join
        repeat (4) @(posedge clk);
        check("grant count simultaneous", addr_log.size(), 2);
        if (addr_log.size() >= 2) begin
            check("first reader_address", addr_log[0], 24'h200000);
            check("second reader_address", addr_log[1], 24'h000010);
        end

        // Reset two cycles into BUSY; a late reader_ready must be ignored.
        #1;
        rd_en       = 1'b0;
        cpu_valid   = 1'b1;
        cpu_address = 24'h0ABCDE;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b1;
        cpu_valid = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        last_cpu = '0;
        last_pcm = '0;
        @(negedge clk);
        check("post-reset reader_valid", reader_valid, 1'b0);
        check("post-reset ready", cpu_ready | pcm_ready, 1'b0);
        check("post-reset cpu_data", cpu_data, 32'h0);
        inject = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late reader_ready ignored (valid)", reader_valid, 1'b0);
            check("late reader_ready ignored (ready)", cpu_ready | pcm_ready, 1'b0);
        end
        check("late reader_ready keeps cpu_data", cpu_data, 32'h0);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        push(1'b0, 24'h000020);
        cpu_req(24'h000020);
        repeat (3) @(posedge clk);
        #1;

        // PCM streaming while the CPU waits.
`ifdef FLASH_ARBITER_STARVATION_GUARD_EN
        for (int i = 0; i < 4; i++) push(1'b1, 24'h300000 + AW'(4 * i));
        push(1'b0, 24'h000040);
        for (int i = 4; i < 6; i++) push(1'b1, 24'h300000 + AW'(4 * i));
        fork
            cpu_req(24'h000040);
            pcm_stream(24'h300000, 6);
        join
`else
        for (int i = 0; i < 20; i++) push(1'b1, 24'h300000 + AW'(4 * i));
        push(1'b0, 24'h000040);
        fork
            cpu_req(24'h000040);
            pcm_stream(24'h300000, 20);
        join
`endif
        repeat (4) @(posedge clk);
        check("scoreboard drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
